// File: rtl/rtc_pkg.sv
// Shared types and defaults for the RTC bus scheduler slice.
package rtc_pkg;

  localparam int unsigned ADDR_W_DEF    = 8;
  localparam int unsigned DATA_W_DEF    = 8;
  localparam int unsigned INIT_HOLD_DEF = 1034;
  localparam logic [6:0]  BOUNDARY_DEF  = 7'h4A;

  // Encodings kept identical to the legacy localparam values.
  typedef enum logic [2:0] {
    ST_INIT   = 3'd0,
    ST_RESYNC = 3'd1,
    ST_READ   = 3'd2,
    ST_WRITE  = 3'd3,
    ST_CRONO  = 3'd4,
    ST_TIMER  = 3'd5
  } rtc_state_t;

  localparam int unsigned G_INIT   = 0;
  localparam int unsigned G_RESYNC = 1;
  localparam int unsigned G_READ   = 2;
  localparam int unsigned G_WRITE  = 3;
  localparam int unsigned G_CRONO  = 4;
  localparam int unsigned G_TIMER  = 5;

  typedef struct packed {
    logic reset;
    logic write;
    logic crono;
    logic timer;
  } rtc_sw_t;

  function automatic logic multi_user(input rtc_sw_t s);
    return (s.write & s.crono) | (s.write & s.timer) | (s.crono & s.timer);
  endfunction

endpackage

// File: rtl/rtc_bus_scheduler_if.sv
// Address/data paths between the sequencers, the scheduler and the protocol engine.
interface rtc_bus_scheduler_if #(
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned DATA_W = 8
);
  logic [ADDR_W-1:0] init_addr;
  logic [DATA_W-1:0] init_data;
  logic [ADDR_W-1:0] rd_addr;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic [ADDR_W-1:0] rtc_addr;
  logic [DATA_W-1:0] rtc_data;
  logic              rtc_rd;

  modport master (
    input  init_addr, init_data, rd_addr, wr_addr, wr_data,
    output rtc_addr, rtc_data, rtc_rd
  );

  modport slave (
    output init_addr, init_data, rd_addr, wr_addr, wr_data,
    input  rtc_addr, rtc_data, rtc_rd
  );
endinterface

// File: rtl/rtc_bus_scheduler_boundary_sync.sv
// Transaction-boundary detector: one bnd pulse per arrival at BOUNDARY, switches gated to it.
module rtc_boundary_sync
  import rtc_pkg::*;
#(
  parameter logic [6:0] BOUNDARY = BOUNDARY_DEF
) (
  input  logic    clk,
  input  logic    reset,
  input  logic [6:0] txn_count,
  input  rtc_sw_t sw_raw,
  output logic    bnd,
  output rtc_sw_t sw_bnd
);

  logic at_bnd;
  logic bnd_q;

  assign at_bnd = (txn_count == BOUNDARY);

  // A counter stalled at BOUNDARY yields only a single event.
  always_ff @(posedge clk) begin
    if (reset) bnd_q <= 1'b0;
    else       bnd_q <= at_bnd;
  end

  assign bnd    = at_bnd & ~bnd_q;
  assign sw_bnd = bnd ? sw_raw : '0;

endmodule

// File: rtl/rtc_bus_scheduler.sv
// Selects which source owns the RTC bus engine, switching only at transaction boundaries.
module rtc_bus_scheduler
  import rtc_pkg::*;
#(
  parameter int unsigned ADDR_W    = ADDR_W_DEF,
  parameter int unsigned DATA_W    = DATA_W_DEF,
  parameter int unsigned INIT_HOLD = INIT_HOLD_DEF,
  parameter logic [6:0]  BOUNDARY  = BOUNDARY_DEF
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] txn_count,
  input  logic       sw_reset,
  input  logic       sw_write,
  input  logic       sw_crono,
  input  logic       sw_timer,
  input  logic       init_done,
  rtc_bus_scheduler_if.master bus,
  output logic [5:0] grant,
  output logic       init_active,
  output logic       conflict
);

  localparam logic [12:0] HOLD_MAX = 13'(INIT_HOLD);

  rtc_state_t        state, state_nxt;
  logic [12:0]       hold_cnt;
  logic              done_seen;
  logic              bnd;
  rtc_sw_t           sw_raw, sw;
  logic [ADDR_W-1:0] addr_mux;
  logic [DATA_W-1:0] data_mux;
  logic              rd_mux;

  assign sw_raw = '{reset: sw_reset, write: sw_write, crono: sw_crono, timer: sw_timer};

  rtc_boundary_sync #(.BOUNDARY(BOUNDARY)) u_bnd (
    .clk       (clk),
    .reset     (reset),
    .txn_count (txn_count),
    .sw_raw    (sw_raw),
    .bnd       (bnd),
    .sw_bnd    (sw)
  );

  always_comb begin
    state_nxt = state;
    if (bnd) begin
      unique case (state)
        ST_INIT:   if (hold_cnt == HOLD_MAX) state_nxt = ST_READ;
        ST_RESYNC: if (done_seen && !sw.reset) state_nxt = ST_READ;
        ST_READ: begin
          if      (sw.reset) state_nxt = ST_RESYNC;
          else if (sw.write) state_nxt = ST_WRITE;
          else if (sw.crono) state_nxt = ST_CRONO;
          else if (sw.timer) state_nxt = ST_TIMER;
        end
        ST_WRITE:  if (sw.reset) state_nxt = ST_RESYNC; else if (!sw.write) state_nxt = ST_READ;
        ST_CRONO:  if (sw.reset) state_nxt = ST_RESYNC; else if (!sw.crono) state_nxt = ST_READ;
        ST_TIMER:  if (sw.reset) state_nxt = ST_RESYNC; else if (!sw.timer) state_nxt = ST_READ;
        default:   state_nxt = ST_INIT;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ST_INIT;
      hold_cnt  <= '0;
      conflict  <= 1'b0;
      done_seen <= 1'b0;
    end else begin
      state <= state_nxt;
      if (hold_cnt != HOLD_MAX) hold_cnt <= hold_cnt + 13'd1;
      if (bnd && state != ST_INIT && multi_user(sw)) conflict <= 1'b1;
      // done_seen only survives while the next state is still an init phase.
      if (state_nxt != ST_INIT && state_nxt != ST_RESYNC) done_seen <= 1'b0;
      else if (init_done)                                 done_seen <= 1'b1;
    end
  end

  always_comb begin
    grant    = '0;
    addr_mux = bus.init_addr;
    data_mux = bus.init_data;
    rd_mux   = 1'b0;
    unique case (state)
      ST_INIT:   grant[G_INIT]   = 1'b1;
      ST_RESYNC: grant[G_RESYNC] = 1'b1;
      ST_READ: begin
        grant[G_READ] = 1'b1;
        addr_mux      = bus.rd_addr;
        data_mux      = '0;
        rd_mux        = 1'b1;
      end
      ST_WRITE, ST_CRONO, ST_TIMER: begin
        if (state == ST_WRITE)      grant[G_WRITE] = 1'b1;
        else if (state == ST_CRONO) grant[G_CRONO] = 1'b1;
        else                        grant[G_TIMER] = 1'b1;
        addr_mux = bus.wr_addr;
        data_mux = bus.wr_data;
      end
      default: grant[G_INIT] = 1'b1;
    endcase
  end

  assign init_active  = (state == ST_INIT) || (state == ST_RESYNC);
  assign bus.rtc_addr = addr_mux;
  assign bus.rtc_data = data_mux;
  assign bus.rtc_rd   = rd_mux;

endmodule

// File: tb/tb_rtc_bus_scheduler.sv
// Directed bench for rtc_bus_scheduler: init window, arbitration, resync, stall, reset.
module tb_rtc_bus_scheduler;

  localparam logic [5:0] GR_INIT   = 6'b000001;
  localparam logic [5:0] GR_RESYNC = 6'b000010;
  localparam logic [5:0] GR_READ   = 6'b000100;
  localparam logic [5:0] GR_WRITE  = 6'b001000;
  localparam logic [5:0] GR_CRONO  = 6'b010000;
  localparam logic [5:0] GR_TIMER  = 6'b100000;

  logic       clk = 1'b0;
  logic       reset;
  logic [6:0] txn_count;
  logic       sw_reset, sw_write, sw_crono, sw_timer, init_done;
  logic [5:0] grant;
  logic       init_active, conflict;
  int         checks = 0;
  int         failures = 0;

  rtc_bus_scheduler_if #(.ADDR_W(8), .DATA_W(8)) bus ();

  rtc_bus_scheduler #(.ADDR_W(8), .DATA_W(8), .INIT_HOLD(1034), .BOUNDARY(7'h4A)) dut (
    .clk         (clk),
    .reset       (reset),
    .txn_count   (txn_count),
    .sw_reset    (sw_reset),
    .sw_write    (sw_write),
    .sw_crono    (sw_crono),
    .sw_timer    (sw_timer),
    .init_done   (init_done),
    .bus         (bus),
    .grant       (grant),
    .init_active (init_active),
    .conflict    (conflict)
  );

  always #5 clk = ~clk;

  task automatic step(input logic [6:0] t);
    txn_count = t;
    @(posedge clk);
    #1;
  endtask

  task automatic run_to(input int from, input int to);
    for (int i = from; i <= to; i++) step(7'(i));
  endtask

  task automatic test_reset;
    reset = 1'b1; sw_reset = 1'b0; sw_write = 1'b0; sw_crono = 1'b0; sw_timer = 1'b0;
    init_done = 1'b0;
    bus.init_addr = 8'hA1; bus.init_data = 8'hB2; bus.rd_addr = 8'hC3;
    bus.wr_addr = 8'hD4; bus.wr_data = 8'hE5;
    step(7'h00); step(7'h00); step(7'h00);
    checks++; if (grant !== GR_INIT) begin failures++; $display("FAIL reset_grant got=%b exp=%b", grant, GR_INIT); end
    checks++; if (bus.rtc_rd !== 1'b0) begin failures++; $display("FAIL reset_rd got=%b exp=0", bus.rtc_rd); end
    checks++; if (init_active !== 1'b1) begin failures++; $display("FAIL reset_init_active got=%b exp=1", init_active); end
    checks++; if (bus.rtc_addr !== 8'hA1) begin failures++; $display("FAIL reset_addr got=%h exp=a1", bus.rtc_addr); end
    checks++; if (bus.rtc_data !== 8'hB2) begin failures++; $display("FAIL reset_data got=%h exp=b2", bus.rtc_data); end
    checks++; if (conflict !== 1'b0) begin failures++; $display("FAIL reset_conflict got=%b exp=0", conflict); end
  endtask

  // Edge k sees txn=(k-1)%75 and hold count k-1; first edge with both at limits is k=1050.
  task automatic test_init_window;
    reset = 1'b0;
    for (int k = 1; k <= 1100; k++) begin
      step(7'((k - 1) % 75));
      if (k == 1 || k == 1049) begin
        checks++; if (grant !== GR_INIT) begin failures++; $display("FAIL init_hold k=%0d got=%b exp=%b", k, grant, GR_INIT); end
      end
      if (k == 1050 || k == 1100) begin
        checks++; if (grant !== GR_READ) begin failures++; $display("FAIL init_exit k=%0d got=%b exp=%b", k, grant, GR_READ); end
      end
    end
    checks++; if (dut.hold_cnt !== 13'd1034) begin failures++; $display("FAIL hold_sat got=%0d exp=1034", dut.hold_cnt); end
    checks++; if (init_active !== 1'b0) begin failures++; $display("FAIL read_init_active got=%b exp=0", init_active); end
  endtask

  task automatic test_write_request;
    run_to(8'h32, 8'h4A);
    run_to(0, 8'h0F);
    sw_write = 1'b1;
    run_to(8'h10, 8'h49);
    checks++; if (grant !== GR_READ) begin failures++; $display("FAIL wr_pre_grant got=%b exp=%b", grant, GR_READ); end
    checks++; if (bus.rtc_rd !== 1'b1) begin failures++; $display("FAIL wr_pre_rd got=%b exp=1", bus.rtc_rd); end
    checks++; if (bus.rtc_addr !== 8'hC3) begin failures++; $display("FAIL wr_pre_addr got=%h exp=c3", bus.rtc_addr); end
    checks++; if (bus.rtc_data !== 8'h00) begin failures++; $display("FAIL wr_pre_data got=%h exp=00", bus.rtc_data); end
    step(7'h4A);
    checks++; if (grant !== GR_WRITE) begin failures++; $display("FAIL wr_grant got=%b exp=%b", grant, GR_WRITE); end
    checks++; if (bus.rtc_addr !== 8'hD4) begin failures++; $display("FAIL wr_addr got=%h exp=d4", bus.rtc_addr); end
    checks++; if (bus.rtc_data !== 8'hE5) begin failures++; $display("FAIL wr_data got=%h exp=e5", bus.rtc_data); end
    checks++; if (bus.rtc_rd !== 1'b0) begin failures++; $display("FAIL wr_rd got=%b exp=0", bus.rtc_rd); end
    checks++; if (conflict !== 1'b0) begin failures++; $display("FAIL wr_conflict got=%b exp=0", conflict); end
  endtask

  task automatic test_conflict;
    sw_write = 1'b0;
    run_to(0, 8'h4A);
    checks++; if (grant !== GR_READ) begin failures++; $display("FAIL cf_back_read got=%b exp=%b", grant, GR_READ); end
    sw_write = 1'b1; sw_crono = 1'b1;
    run_to(0, 8'h4A);
    checks++; if (grant !== GR_WRITE) begin failures++; $display("FAIL cf_prio got=%b exp=%b", grant, GR_WRITE); end
    checks++; if (conflict !== 1'b1) begin failures++; $display("FAIL cf_set got=%b exp=1", conflict); end
    sw_crono = 1'b0;
    run_to(0, 8'h4A);
    checks++; if (grant !== GR_WRITE) begin failures++; $display("FAIL cf_stay got=%b exp=%b", grant, GR_WRITE); end
    checks++; if (conflict !== 1'b1) begin failures++; $display("FAIL cf_sticky got=%b exp=1", conflict); end
    sw_write = 1'b0; sw_crono = 1'b1;
    run_to(0, 8'h4A);
    checks++; if (grant !== GR_READ) begin failures++; $display("FAIL cf_own_low got=%b exp=%b", grant, GR_READ); end
    run_to(0, 8'h4A);
    checks++; if (grant !== GR_CRONO) begin failures++; $display("FAIL crono_grant got=%b exp=%b", grant, GR_CRONO); end
    checks++; if (bus.rtc_addr !== 8'hD4) begin failures++; $display("FAIL crono_addr got=%h exp=d4", bus.rtc_addr); end
    sw_crono = 1'b0; sw_write = 1'b1;
    run_to(0, 8'h4A);
    run_to(0, 8'h4A);
    checks++; if (grant !== GR_WRITE) begin failures++; $display("FAIL cf_rewrite got=%b exp=%b", grant, GR_WRITE); end
  endtask

  task automatic test_resync;
    sw_reset = 1'b1;
    run_to(0, 8'h4A);
    checks++; if (grant !== GR_RESYNC) begin failures++; $display("FAIL rs_enter got=%b exp=%b", grant, GR_RESYNC); end
    checks++; if (init_active !== 1'b1) begin failures++; $display("FAIL rs_active got=%b exp=1", init_active); end
    checks++; if (bus.rtc_addr !== 8'hA1) begin failures++; $display("FAIL rs_addr got=%h exp=a1", bus.rtc_addr); end
    sw_reset = 1'b0; sw_write = 1'b0;
    run_to(0, 8'h4A);
    checks++; if (grant !== GR_RESYNC) begin failures++; $display("FAIL rs_wait_done got=%b exp=%b", grant, GR_RESYNC); end
    run_to(0, 4);
    init_done = 1'b1; step(7'h05); init_done = 1'b0;
    run_to(6, 8'h4A);
    checks++; if (grant !== GR_READ) begin failures++; $display("FAIL rs_exit got=%b exp=%b", grant, GR_READ); end
    run_to(0, 4);
    init_done = 1'b1; step(7'h05); init_done = 1'b0;
    sw_reset = 1'b1;
    run_to(6, 8'h4A);
    sw_reset = 1'b0;
    run_to(0, 8'h4A);
    checks++; if (grant !== GR_RESYNC) begin failures++; $display("FAIL rs_stray_done got=%b exp=%b", grant, GR_RESYNC); end
    init_done = 1'b1; step(7'h00); init_done = 1'b0;
    run_to(1, 8'h4A);
    checks++; if (grant !== GR_READ) begin failures++; $display("FAIL rs_exit2 got=%b exp=%b", grant, GR_READ); end
  endtask

  task automatic test_stall;
    run_to(0, 8'h49);
    sw_timer = 1'b1;
    step(7'h4A);
    checks++; if (grant !== GR_TIMER) begin failures++; $display("FAIL stall_enter got=%b exp=%b", grant, GR_TIMER); end
    sw_timer = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step(7'h4A);
      checks++; if (grant !== GR_TIMER) begin failures++; $display("FAIL stall_hold i=%0d got=%b exp=%b", i, grant, GR_TIMER); end
    end
    sw_timer = 1'b1;
  endtask

  task automatic test_reset_midtxn;
    run_to(0, 8'h1F);
    checks++; if (grant !== GR_TIMER) begin failures++; $display("FAIL mid_pre got=%b exp=%b", grant, GR_TIMER); end
    reset = 1'b1;
    step(7'h20);
    reset = 1'b0;
    checks++; if (grant !== GR_INIT) begin failures++; $display("FAIL mid_grant got=%b exp=%b", grant, GR_INIT); end
    checks++; if (conflict !== 1'b0) begin failures++; $display("FAIL mid_conflict got=%b exp=0", conflict); end
    checks++; if (dut.hold_cnt !== 13'd0) begin failures++; $display("FAIL mid_hold got=%0d exp=0", dut.hold_cnt); end
    checks++; if (bus.rtc_addr !== 8'hA1) begin failures++; $display("FAIL mid_addr got=%h exp=a1", bus.rtc_addr); end
    run_to(8'h21, 8'h4A);
    checks++; if (grant !== GR_INIT) begin failures++; $display("FAIL mid_hold_init got=%b exp=%b", grant, GR_INIT); end
    checks++; if (dut.hold_cnt !== 13'd42) begin failures++; $display("FAIL mid_hold_cnt got=%0d exp=42", dut.hold_cnt); end
  endtask

  initial begin
    test_reset();
    test_init_window();
    test_write_request();
    test_conflict();
    test_resync();
    test_stall();
    test_reset_midtxn();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
